demux_buf: RTL and testbench
============================

// Module: demux_buf
// PURPOSE
// - Registered 1-to-NUM_OUT demultiplexer with a valid/ready handshake on both sides.
// - Steers each word from one source to one destination selected by in_sel.
// - Sits between a single producer (e.g. datapath write port) and several sinks
//   (memory, I/O registers, display).
// - One-entry output buffer: 1-cycle latency, full throughput when the selected
//   sink is ready.
// PARAMETERS
// - DATA_W   16  width of the data word
// - NUM_OUT   4  number of destinations, range 2..2**SEL_W
// - SEL_W     2  width of in_sel; must satisfy 2**SEL_W >= NUM_OUT
// PORTS
// - clk        in   1        rising-edge clock, the only clock
// - reset      in   1        asynchronous, active-high reset
// - in_valid   in   1        source word valid
// - in_ready   out  1        block accepts the source word this cycle
// - in_data    in   DATA_W   source word
// - in_sel     in   SEL_W    destination index; sampled together with in_data
// - out_valid  out  NUM_OUT  one-hot; bit k = buffered word is for sink k
// - out_ready  in   NUM_OUT  per-sink ready
// - out_data   out  DATA_W   buffered word, shared by all sinks
// - sel_err    out  1        1-cycle pulse: an out-of-range word was dropped
// - err_count  out  8        saturating count of dropped words (see CONFIGURATION)
// BEHAVIOUR
// - Storage: state bit full_q, data_q[DATA_W-1:0], sel_q[SEL_W-1:0].
// - Reset (async, asserted): full_q=0, data_q=0, sel_q=0, sel_err=0, err_count=0.
//   - Outputs during reset: out_valid=0, out_data=0, in_ready=1.
// - Combinational outputs:
//   - out_valid[k] = full_q && (sel_q==k)
//   - out_data = data_q
//   - drain = full_q && out_ready[sel_q]
//   - in_ready = !full_q || drain  (ready is combinational from out_ready)
// - Accept: accept = in_valid && in_ready, sampled at the rising clk edge.
// - States:
//   - EMPTY (full_q=0):
//     - accept with in_sel<NUM_OUT -> FULL; data_q<=in_data, sel_q<=in_sel.
//     - Otherwise stay EMPTY.
//   - FULL (full_q=1):
//     - drain and a valid accept on the same edge -> stay FULL; new word loaded,
//       so back-to-back transfers have no bubble.
//     - drain with no valid accept -> EMPTY.
//     - No drain -> hold data_q and sel_q unchanged; out_ready of non-selected
//       sinks is ignored.
// - Latency: a word accepted at edge N shows on out_valid/out_data after edge N.
// - Out-of-range select (in_sel >= NUM_OUT):
//   - The word is still accepted (in_ready rules unchanged) and discarded; it is
//     never buffered.
//   - sel_err=1 for exactly the cycle after the accepting edge.
//   - If FULL and drained on that edge -> EMPTY.
// - A source must hold in_valid/in_data/in_sel until accepted; the block does not
//   check this.
// - Reset mid-operation: a buffered word is discarded; no out_valid after release
//   until a new accept.
// - sel_err is registered; it is 0 whenever no drop occurred on the previous edge.
// CONFIGURATION
// - Macro DEMUX_BUF_ERR_CNT_EN.
// - Defined: err_count increments by 1 on each out-of-range accept and saturates
//   at 8'hFF. Only reset clears it.
// - Undefined: no counter is built; err_count is tied to 8'h00. sel_err is
//   unaffected.
// TESTING
// 1. After reset, out_ready=0: drive in_valid=1, in_sel=2, in_data=16'h1234 for one
//    edge -> next cycle out_valid=4'b0100, out_data=16'h1234, in_ready=0. Hold for
//    5 cycles, then out_ready=4'b0100 -> next cycle out_valid=0.
// 2. Streaming, out_ready=4'b1111: sels 0,1,2,3 with data 16'hA0..16'hA3 on
//    consecutive edges -> out_valid 0001,0010,0100,1000 on consecutive cycles;
//    in_ready stays 1; no bubbles.
// 3. Holding sel=1, out_ready=4'b1101 for 4 cycles -> word held, in_ready=0;
//    out_ready[1]=1 with a new word in_sel=3 on the same edge -> out_valid=4'b1000.
// 4. NUM_OUT=3, accept in_sel=3, in_data=16'hDEAD -> no out_valid bit set; sel_err
//    high exactly 1 cycle; err_count=1 with EN defined, 0 without.
// 5. With EN defined: 300 consecutive out-of-range accepts -> err_count=8'hFF.
// 6. Assert reset asynchronously (mid-cycle) while FULL -> out_valid=0 and
//    in_ready=1 immediately; after release, no output until a new accept.

Source files
------------

// File: rtl/demux_buf_if.sv
// Handshake bundle for demux_buf: one source side, NUM_OUT sink sides sharing one data bus.
interface demux_buf_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned SEL_W   = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SEL_W-1:0]   in_sel;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               sel_err;
  logic [7:0]         err_count;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, sel_err, err_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, sel_err, err_count
  );
endinterface

// File: rtl/demux_buf.sv
// Registered 1-to-NUM_OUT demultiplexer with a one-entry output buffer.
// Optional saturating drop counter is built when DEMUX_BUF_ERR_CNT_EN is defined.
module demux_buf #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  demux_buf_if.slave   bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [SEL_W:0] SEL_LIM = (SEL_W+1)'(NUM_OUT);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                sel_err_q;
  logic                full_c;
  logic                drain_c;
  logic                in_ready_c;
  logic                accept_c;
  logic                in_range_c;
  logic                drop_c;
  logic [NUM_OUT-1:0]  out_valid_c;

  assign full_c = (state_q == FULL);

  // One-hot destination decode of the buffered select; drain only looks at that sink.
  always_comb begin
    out_valid_c = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_valid_c[k] = full_c && (sel_q == SEL_W'(k));
    end
  end

  assign drain_c    = |(out_valid_c & bus.out_ready);
  assign in_ready_c = !full_c || drain_c;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign in_range_c = ({1'b0, bus.in_sel} < SEL_LIM);
  assign drop_c     = accept_c && !in_range_c;

  // State register and buffered payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      sel_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      sel_err_q <= drop_c;
    end
  end

  // Next-state: an accept while FULL implies a drain, so a valid load keeps FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    case (state_q)
      EMPTY: begin
        if (accept_c && in_range_c) begin
          state_d = FULL;
          data_d  = bus.in_data;
          sel_d   = bus.in_sel;
        end
      end
      FULL: begin
        if (accept_c && in_range_c) begin
          data_d = bus.in_data;
          sel_d  = bus.in_sel;
        end else if (drain_c) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = data_q;
  assign bus.in_ready  = in_ready_c;
  assign bus.sel_err   = sel_err_q;

`ifdef DEMUX_BUF_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Saturating count of dropped out-of-range words; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (drop_c && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf: a 4-sink instance for the main flow and a 3-sink
// instance for out-of-range drops.
module tb_demux_buf;

`ifdef DEMUX_BUF_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  demux_buf_if #(.DATA_W(16), .NUM_OUT(4), .SEL_W(2)) bus_a ();
  demux_buf_if #(.DATA_W(16), .NUM_OUT(3), .SEL_W(2)) bus_b ();

  demux_buf #(.DATA_W(16), .NUM_OUT(4), .SEL_W(2)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  demux_buf #(.DATA_W(16), .NUM_OUT(3), .SEL_W(2)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_sel = '0; bus_a.out_ready = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_sel = '0; bus_b.out_ready = '0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus_a.out_valid), 32'h0);
    check("rst_out_data",  32'(bus_a.out_data),  32'h0);
    check("rst_in_ready",  32'(bus_a.in_ready),  32'h1);
    check("rst_sel_err",   32'(bus_a.sel_err),   32'h0);
    check("rst_err_count", 32'(bus_a.err_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1: single word to sink 2, held while sink stalls
    bus_a.in_valid = 1'b1; bus_a.in_sel = 2'd2; bus_a.in_data = 16'h1234;
    #1;
    check("t1_in_ready_empty", 32'(bus_a.in_ready), 32'h1);
    tick();
    bus_a.in_valid = 1'b0;
    #1;
    check("t1_out_valid", 32'(bus_a.out_valid), 32'h4);
    check("t1_out_data",  32'(bus_a.out_data),  32'h1234);
    check("t1_in_ready",  32'(bus_a.in_ready),  32'h0);
    repeat (5) tick();
    check("t1_hold_valid", 32'(bus_a.out_valid), 32'h4);
    check("t1_hold_ready", 32'(bus_a.in_ready),  32'h0);
    bus_a.out_ready = 4'b0100;
    #1;
    check("t1_drain_ready", 32'(bus_a.in_ready), 32'h1);
    tick();
    check("t1_empty", 32'(bus_a.out_valid), 32'h0);

    // 2: streaming to all sinks with no bubbles
    bus_a.out_ready = 4'b1111;
    bus_a.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_sel  = 2'(i);
      bus_a.in_data = 16'(16'hA0 + i);
      tick();
      check("t2_out_valid", 32'(bus_a.out_valid), 32'(1 << i));
      check("t2_out_data",  32'(bus_a.out_data),  32'(16'hA0 + i));
      check("t2_in_ready",  32'(bus_a.in_ready),  32'h1);
    end
    bus_a.in_valid = 1'b0;
    tick();
    check("t2_empty", 32'(bus_a.out_valid), 32'h0);

    // 3: non-selected sink readies are ignored; drain + reload on one edge
    bus_a.out_ready = 4'b1101;
    bus_a.in_valid = 1'b1; bus_a.in_sel = 2'd1; bus_a.in_data = 16'hBEEF;
    tick();
    bus_a.in_valid = 1'b0;
    repeat (4) tick();
    check("t3_hold_valid", 32'(bus_a.out_valid), 32'h2);
    check("t3_hold_data",  32'(bus_a.out_data),  32'hBEEF);
    check("t3_hold_ready", 32'(bus_a.in_ready),  32'h0);
    bus_a.out_ready = 4'b1111;
    bus_a.in_valid = 1'b1; bus_a.in_sel = 2'd3; bus_a.in_data = 16'hC0DE;
    #1;
    check("t3_swap_ready", 32'(bus_a.in_ready), 32'h1);
    tick();
    bus_a.in_valid = 1'b0;
    check("t3_swap_valid", 32'(bus_a.out_valid), 32'h8);
    check("t3_swap_data",  32'(bus_a.out_data),  32'hC0DE);
    tick();
    check("t3_empty", 32'(bus_a.out_valid), 32'h0);

    // 4: out-of-range select on the 3-sink instance
    bus_b.in_valid = 1'b1; bus_b.in_sel = 2'd3; bus_b.in_data = 16'hDEAD;
    tick();
    bus_b.in_valid = 1'b0;
    check("t4_no_valid",  32'(bus_b.out_valid), 32'h0);
    check("t4_sel_err",   32'(bus_b.sel_err),   32'h1);
    check("t4_err_count", 32'(bus_b.err_count), CNT_EN ? 32'h1 : 32'h0);
    tick();
    check("t4_sel_err_clr", 32'(bus_b.sel_err), 32'h0);
    // FULL and drained on the same edge as a drop -> EMPTY
    bus_b.in_valid = 1'b1; bus_b.in_sel = 2'd2; bus_b.in_data = 16'h0055;
    tick();
    check("t4_full_valid", 32'(bus_b.out_valid), 32'h4);
    bus_b.out_ready = 3'b100; bus_b.in_sel = 2'd3; bus_b.in_data = 16'hDEAD;
    tick();
    bus_b.in_valid = 1'b0; bus_b.out_ready = 3'b000;
    check("t4_drop_empty", 32'(bus_b.out_valid), 32'h0);
    check("t4_drop_err",   32'(bus_b.sel_err),   32'h1);
    check("t4_drop_cnt",   32'(bus_b.err_count), CNT_EN ? 32'h2 : 32'h0);

`ifdef DEMUX_BUF_ERR_CNT_EN
    // 5: counter saturates instead of wrapping
    bus_b.in_valid = 1'b1; bus_b.in_sel = 2'd3;
    repeat (300) tick();
    bus_b.in_valid = 1'b0;
    check("t5_saturate", 32'(bus_b.err_count), 32'hFF);
`endif

    // 6: asynchronous reset mid-cycle while FULL
    bus_a.out_ready = 4'b0000;
    bus_a.in_valid = 1'b1; bus_a.in_sel = 2'd0; bus_a.in_data = 16'h0A0A;
    tick();
    bus_a.in_valid = 1'b0;
    check("t6_full", 32'(bus_a.out_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus_a.out_valid), 32'h0);
    check("t6_rst_ready", 32'(bus_a.in_ready),  32'h1);
    check("t6_rst_cnt",   32'(bus_b.err_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("t6_post_empty", 32'(bus_a.out_valid), 32'h0);
    bus_a.in_valid = 1'b1; bus_a.in_sel = 2'd1; bus_a.in_data = 16'h0077;
    tick();
    bus_a.in_valid = 1'b0;
    check("t6_new_valid", 32'(bus_a.out_valid), 32'h2);
    check("t6_new_data",  32'(bus_a.out_data),  32'h0077);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
